// File: rtl/midi_tx.sv
// midi_tx: turns note-on/off events into 3-byte MIDI channel messages on a 31250-baud UART line.
// Optional build macro MIDI_RUNNING_STATUS_EN suppresses a status byte equal to the previous one.
module midi_tx #(
  parameter int unsigned CLKS_PER_BIT = 384,
  parameter int unsigned CHANNEL      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       event_valid,
  output logic       event_ready,
  input  logic       event_on,
  input  logic [6:0] event_note,
  input  logic [6:0] event_velocity,
  output logic       midi_out,
  output logic       busy,
  output logic       byte_valid,
  output logic [7:0] byte_value
);

  localparam int unsigned   CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_NOTE, SEND_VEL} state_t;
  typedef enum logic [1:0] {PH_START, PH_DATA, PH_STOP} phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [6:0]    note_q, vel_q;
  logic          midi_out_q, byte_valid_q;
  logic [7:0]    byte_value_q;

  logic [7:0]    status_d;
  logic          skip_d, launch_d, byte_end;
  logic [7:0]    launch_byte_d;

  assign status_d = {1'b1, 2'b00, event_on, 4'(CHANNEL)};

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q;
  logic       last_valid_q;
  assign skip_d = last_valid_q && (last_status_q == status_d);
`else
  assign skip_d = 1'b0;
`endif

  assign byte_end = (state_q != IDLE) && (phase_q == PH_STOP) && (cnt_q == '0);

  // Next byte is launched in the cycle right after the previous stop bit, so frames abut.
  always_comb begin
    state_d       = state_q;
    launch_d      = 1'b0;
    launch_byte_d = '0;
    case (state_q)
      IDLE: begin
        if (event_valid) begin
          launch_d = 1'b1;
          if (skip_d) begin
            state_d       = SEND_NOTE;
            launch_byte_d = {1'b0, event_note};
          end else begin
            state_d       = SEND_STATUS;
            launch_byte_d = status_d;
          end
        end
      end
      SEND_STATUS: if (byte_end) begin
        state_d       = SEND_NOTE;
        launch_d      = 1'b1;
        launch_byte_d = {1'b0, note_q};
      end
      SEND_NOTE: if (byte_end) begin
        state_d       = SEND_VEL;
        launch_d      = 1'b1;
        launch_byte_d = {1'b0, vel_q};
      end
      SEND_VEL: if (byte_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    byte_valid_q <= 1'b0;
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= PH_START;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      note_q       <= '0;
      vel_q        <= '0;
      midi_out_q   <= 1'b1;
      byte_value_q <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status_q <= '0;
      last_valid_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && event_valid) begin
        note_q <= event_note;
        vel_q  <= event_velocity;
`ifdef MIDI_RUNNING_STATUS_EN
        last_status_q <= status_d;
        last_valid_q  <= 1'b1;
`endif
      end
      if (launch_d) begin
        shift_q      <= launch_byte_d;
        byte_value_q <= launch_byte_d;
        byte_valid_q <= 1'b1;
        midi_out_q   <= 1'b0;
        phase_q      <= PH_START;
        cnt_q        <= CNT_LOAD;
      end else if (state_q != IDLE) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          cnt_q <= CNT_LOAD;
          case (phase_q)
            PH_START: begin
              phase_q    <= PH_DATA;
              idx_q      <= '0;
              midi_out_q <= shift_q[0];
            end
            PH_DATA: begin
              if (idx_q == 3'd7) begin
                phase_q    <= PH_STOP;
                midi_out_q <= 1'b1;
              end else begin
                idx_q      <= idx_q + 3'd1;
                shift_q    <= {1'b0, shift_q[7:1]};
                midi_out_q <= shift_q[1];
              end
            end
            default: midi_out_q <= 1'b1;
          endcase
        end
      end
    end
  end

  assign event_ready = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign midi_out    = midi_out_q;
  assign byte_valid  = byte_valid_q;
  assign byte_value  = byte_value_q;

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: two instances (channel 0 and 5) share stimulus and are checked each cycle
// against a frame-arithmetic model, plus literal expectations from hand-worked messages.
module tb_midi_tx;
  localparam int CPB  = 4;
  localparam int BITS = 10 * CPB;
  localparam int NCAP = 200;

  logic       clk = 1'b0, rst = 1'b1;
  logic       event_valid = 1'b0, event_on = 1'b0;
  logic [6:0] event_note = '0, event_velocity = '0;
  logic       rdy0, out0, busy0, bv0, rdy5, out5, busy5, bv5;
  logic [7:0] val0, val5;

  always #5 clk = ~clk;

  midi_tx #(.CLKS_PER_BIT(CPB), .CHANNEL(0)) u0 (
    .clk(clk), .rst(rst), .event_valid(event_valid), .event_ready(rdy0), .event_on(event_on),
    .event_note(event_note), .event_velocity(event_velocity), .midi_out(out0), .busy(busy0),
    .byte_valid(bv0), .byte_value(val0));

  midi_tx #(.CLKS_PER_BIT(CPB), .CHANNEL(5)) u5 (
    .clk(clk), .rst(rst), .event_valid(event_valid), .event_ready(rdy5), .event_on(event_on),
    .event_note(event_note), .event_velocity(event_velocity), .midi_out(out5), .busy(busy5),
    .byte_valid(bv5), .byte_value(val5));

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a message is a list of bytes, each a 10-bit frame of CPB-cycle bits.
  logic       m_active = 1'b0, m_on = 1'b0, m_skip = 1'b0, m_lv = 1'b0, m_last_on = 1'b0;
  logic [6:0] m_note = '0, m_vel = '0;
  int         m_t = 0, m_len = 0;

  function automatic logic rs_skip();
`ifdef MIDI_RUNNING_STATUS_EN
    return m_lv && (m_last_on == event_on);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input int ch, input int k);
    int idx;
    idx = m_skip ? k + 1 : k;
    case (idx)
      0:       return {1'b1, 2'b00, m_on, 4'(ch)};
      1:       return {1'b0, m_note};
      default: return {1'b0, m_vel};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_lv     <= 1'b0;
    end else if (m_active) begin
      if (m_t == m_len - 1) m_active <= 1'b0;
      else m_t <= m_t + 1;
    end else if (event_valid) begin
      m_active  <= 1'b1;
      m_t       <= 0;
      m_on      <= event_on;
      m_note    <= event_note;
      m_vel     <= event_velocity;
      m_skip    <= rs_skip();
      m_len     <= (rs_skip() ? 2 : 3) * BITS;
      m_lv      <= 1'b1;
      m_last_on <= event_on;
    end
  end

  task automatic cmp_inst(input string nm, input int ch, input logic o, input logic bv,
                          input logic [7:0] v, input logic b, input logic r);
    logic eo, ebv, eb, er;
    logic [7:0] ev;
    int bt, bi;
    ev = '0;
    if (m_active) begin
      bt  = m_t % BITS;
      bi  = bt / CPB;
      ev  = exp_byte(ch, m_t / BITS);
      eo  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : ev[bi-1];
      ebv = (bt == 0);
      eb  = 1'b1;
      er  = 1'b0;
    end else begin
      eo = 1'b1; ebv = 1'b0; eb = 1'b0; er = !rst;
    end
    checks++;
    if (o !== eo || bv !== ebv || b !== eb || r !== er || (ebv && v !== ev)) begin
      failures++;
      $display("FAIL cycle_%s t=%0d out/bv/val/busy/rdy got %b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
               nm, m_t, o, bv, v, b, r, eo, ebv, ev, eb, er);
    end
  endtask

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst("u0", 0, out0, bv0, val0, busy0, rdy0);
      cmp_inst("u5", 5, out5, bv5, val5, busy5, rdy5);
    end
  end

  logic       c_out0[NCAP], c_bv0[NCAP], c_rdy0[NCAP], c_busy0[NCAP];
  logic [7:0] c_val0[NCAP], c_val5[NCAP];

  task automatic scramble();
    event_on       = 1'($urandom);
    event_note     = 7'($urandom);
    event_velocity = 7'($urandom);
  endtask

  task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
    @(posedge clk); #1;
    event_valid = 1'b1; event_on = on; event_note = n; event_velocity = v;
  endtask

  // Sample i is the i-th cycle after the acceptance edge.
  task automatic capture(input int n, input bit wiggle, input int rst_at);
    @(posedge clk); #1;
    if (wiggle) scramble(); else event_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c_out0[i] = out0; c_bv0[i] = bv0; c_rdy0[i] = rdy0; c_busy0[i] = busy0;
      c_val0[i] = val0; c_val5[i] = val5;
      @(posedge clk); #1;
      if (i == rst_at) rst = 1'b1;
      else if (i == rst_at + 1) rst = 1'b0;
      if (wiggle) scramble();
    end
    event_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(rdy0 && rdy5) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 32'(k < 400), 32'd1);
  endtask

  function automatic int first_ready(input int n);
    for (int i = 0; i < n; i++) if (c_rdy0[i]) return i;
    return -1;
  endfunction

  function automatic int count_bv(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (c_bv0[i]) c++;
    return c;
  endfunction

  initial begin
    logic seq[10];
    bit ok;
    seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_out", 32'(out0), 32'd1);
    check("rst_val", 32'(val0), 32'h00);
    check("rst_ready", 32'(rdy0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);

    // Note-on 0x3C/0x64, channel 0 (and channel 5 in parallel)
    send(1'b1, 7'h3C, 7'h64);
    capture(130, 1'b0, -1);
    check("t1_nbytes", 32'(count_bv(130)), 32'd3);
    check("t1_b0", {c_bv0[0], c_val0[0]}, {1'b1, 8'h90});
    check("t1_b1", {c_bv0[40], c_val0[40]}, {1'b1, 8'h3C});
    check("t1_b2", {c_bv0[80], c_val0[80]}, {1'b1, 8'h64});
    check("t1_start_low", 32'(c_out0[0]), 32'd0);
    check("t1_ready_low_len", 32'(first_ready(130)), 32'd120);
    check("t1_u5_status", 32'(c_val5[0]), 32'h95);
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int j = 0; j < CPB; j++) if (c_out0[b*CPB+j] !== seq[b]) ok = 1'b0;
      check($sformatf("t2_bit%0d", b), 32'(ok), 32'd1);
    end
    wait_idle();

    // Note-off 0x3C/0x40
    send(1'b0, 7'h3C, 7'h40);
    capture(130, 1'b0, -1);
    check("t3_u5_b0", 32'(c_val5[0]), 32'h85);
    check("t3_u5_b1", 32'(c_val5[40]), 32'h3C);
    check("t3_u5_b2", 32'(c_val5[80]), 32'h40);
    check("t3_u0_b0", 32'(c_val0[0]), 32'h80);
    wait_idle();

    // event_valid held with inputs scrambled every cycle while busy
    send(1'b1, 7'h10, 7'h20);
    capture(130, 1'b1, -1);
    check("t4_b0", 32'(c_val0[0]), 32'h90);
    check("t4_b1", 32'(c_val0[40]), 32'h10);
    check("t4_b2", 32'(c_val0[80]), 32'h20);
    check("t4_ready_rise", {c_rdy0[119], c_rdy0[120]}, 2'b01);
    check("t4_reaccept", {c_bv0[121], c_out0[121]}, 2'b10);
    wait_idle();

    // Reset pulse landing during data bit 3 of the note byte
    send(1'b1, 7'h3C, 7'h64);
    capture(64, 1'b0, 57);
    check("t5_pre_rst", {c_busy0[58], c_out0[58]}, 2'b11);
    check("t5_post_rst", {c_out0[59], c_rdy0[59], c_busy0[59]}, 3'b110);
    check("t5_no_bv", 32'(count_bv(64) - 32'(c_bv0[0]) - 32'(c_bv0[40])), 32'd0);
    send(1'b1, 7'h3C, 7'h64);
    capture(130, 1'b0, -1);
    check("t5_full_n", 32'(count_bv(130)), 32'd3);
    check("t5_full_b0", 32'(c_val0[0]), 32'h90);
    wait_idle();

    // Running status sequence
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(1'b1, 7'h3C, 7'h64);
    capture(130, 1'b0, -1);
    check("t6_first_b0", 32'(c_val0[0]), 32'h90);
    wait_idle();
    send(1'b1, 7'h3E, 7'h50);
    capture(130, 1'b0, -1);
`ifdef MIDI_RUNNING_STATUS_EN
    check("t6_rs_b0", 32'(c_val0[0]), 32'h3E);
    check("t6_rs_b1", 32'(c_val0[40]), 32'h50);
    check("t6_rs_n", 32'(count_bv(130)), 32'd2);
    check("t6_rs_len", 32'(first_ready(130)), 32'd80);
`else
    check("t6_b0", 32'(c_val0[0]), 32'h90);
    check("t6_b1", 32'(c_val0[40]), 32'h3E);
    check("t6_len", 32'(first_ready(130)), 32'd120);
`endif
    wait_idle();
    send(1'b0, 7'h3C, 7'h00);
    capture(130, 1'b0, -1);
    check("t6_off_b0", 32'(c_val0[0]), 32'h80);
    check("t6_off_b1", 32'(c_val0[40]), 32'h3C);
    check("t6_off_b2", 32'(c_val0[80]), 32'h00);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
Transmit-side counterpart of the MIDI byte parser (midi_fsm). Accepts note-on/note-off events over a valid/ready handshake and builds the 3-byte MIDI channel message. Serializes each byte as a 31250-baud UART frame on the MIDI OUT line. Also reports each launched byte on a parallel valid/value strobe, so it can be looped directly into midi_fsm in benches.

Parameters:
CLKS_PER_BIT, 384, clk cycles per UART bit (12 MHz / 31250); legal range >= 2
CHANNEL, 0, MIDI channel 0-15, placed in the status byte low nibble

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
event_valid  input  1  event request
event_ready  output  1  block can accept an event
event_on  input  1  1 = note on, 0 = note off
event_note  input  7  note number
event_velocity  input  7  velocity
midi_out  output  1  UART serial line, idle high
busy  output  1  message in progress
byte_valid  output  1  one-cycle pulse at start of each byte frame
byte_value  output  8  byte being launched, valid with byte_valid

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: midi_out=1, busy=0, byte_valid=0, byte_value=0, event_ready=1. Reset also clears the running-status memory.
- Handshake:
  - event_ready = (state==IDLE) && !rst, combinational from state.
  - An event is accepted on a posedge where event_valid && event_ready.
  - event_on, event_note and event_velocity are captured at acceptance; later input changes are ignored.
- Message format:
  - status = {1'b1, event_on ? 3'b001 : 3'b000, CHANNEL[3:0]}.
  - Then {1'b0, note}, then {1'b0, velocity}.
- Byte-level FSM: IDLE -> SEND_STATUS -> SEND_NOTE -> SEND_VEL -> IDLE.
- Bit-level serializer per byte: START (midi_out=0), DATA x8 (LSB first), STOP (midi_out=1).
  - Each bit is held exactly CLKS_PER_BIT cycles via a down-counter.
  - A 3-bit index counts data bits.
- Latency:
  - midi_out drives the start bit in the first cycle after the acceptance edge.
  - byte_valid pulses in that same first start-bit cycle, with byte_value = status.
- Byte spacing:
  - Bytes within one message are back-to-back, with no idle gap after a stop bit.
  - One full message occupies 30*CLKS_PER_BIT cycles.
- Message end:
  - After the last stop-bit cycle, state returns to IDLE; event_ready and !busy assert in the next cycle.
  - Consecutive messages are therefore separated by at least the one acceptance cycle at idle-high.
- busy = !IDLE.
- Reset mid-operation: the frame is aborted. Next cycle: midi_out=1, state IDLE, no further byte_valid. No partial-byte recovery.
- event_valid while busy: ignored. No queueing and no error flag.

Optional Feature:
MIDI_RUNNING_STATUS_EN
- Defined:
  - A last_status register holds the most recently transmitted status byte, with a valid bit cleared on reset.
  - If the new status equals last_status and the valid bit is set, SEND_STATUS is skipped: FSM goes IDLE -> SEND_NOTE, and the message is 20*CLKS_PER_BIT cycles.
  - Start-bit latency is unchanged; the first byte_valid carries the note byte.
  - A differing status is sent and updates last_status.
- Undefined: status byte always sent; no last_status register.

Test Plan:
1. CLKS_PER_BIT=4, CHANNEL=0, accept on=1 note=0x3C vel=0x64.
   - byte_valid pulses with 0x90, 0x3C, 0x64 at 40-cycle intervals.
   - midi_out low in the cycle after acceptance.
   - event_ready low for exactly 120 cycles.
2. Bit timing on 0x90: midi_out sequence 0,0,0,0,0,1,0,0,1,1 (start, LSB-first data, stop), each level held exactly 4 cycles.
3. Note off: on=0, note=0x3C, vel=0x40, CHANNEL=5 -> bytes 0x85, 0x3C, 0x40.
4. event_valid held high with data changing every cycle while busy -> only the values present at the acceptance edge are sent; the next acceptance occurs the cycle after event_ready rises.
5. rst pulse during data bit 3 of the note byte:
   - next cycle midi_out=1, event_ready=1, busy=0.
   - a following note-on sends a full 3-byte message, including status with MIDI_RUNNING_STATUS_EN defined.
6. MIDI_RUNNING_STATUS_EN defined:
   - note-on 0x3C/0x64, then note-on 0x3E/0x50 -> second message is bytes 0x3E, 0x50 only, 80 cycles.
   - then note-off 0x3C/0x00 -> 0x80 re-sent.
